// File: rtl/button_pio_dbnc.sv
// Debounced button PIO: input synchronizer, tick-based per-channel debounce,
// edge capture with W1C clear, level interrupt and an Avalon-MM register file.

module button_pio_dbnc_lane #(
   parameter int   DB_TICKS  = 4,
   parameter logic RST_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync,
   input  logic tick,
   input  logic bypass,
   output logic db
);
   logic [3:0] cnt;

   // Any cycle where sync agrees with the accepted level discards the partial count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         db  <= RST_LEVEL;
      end else if (bypass || sync == db) begin
         cnt <= '0;
         db  <= sync;
      end else if (tick) begin
         if (cnt == 4'(DB_TICKS - 1)) begin
            cnt <= '0;
            db  <= sync;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end
endmodule

module button_pio_dbnc #(
   parameter int               WIDTH           = 4,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DB_TICKS        = 4,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '1,
   parameter logic [15:0]      RESET_DB_PERIOD = 16'd50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_pipe;
   logic [WIDTH-1:0] sync, db, db_d1, rise, fall, w1c;
   logic [WIDTH-1:0] irq_mask, edge_capture, rise_en, fall_en;
   logic [15:0]      db_period, presc;
   logic [31:0]      rd_next;
   logic             wr, tick, bypass;
   logic             unused_wdata;

   assign unused_wdata = &{1'b0, writedata[31:16]};
   assign wr     = chipselect & ~write_n;
   assign sync   = sync_pipe[SYNC_STAGES-1];
   assign tick   = (presc == 16'd0);
   assign bypass = (db_period == 16'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_pipe <= {SYNC_STAGES{RESET_LEVEL}};
      else          sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], in_port};
   end

   // Writing the period restarts the prescaler so the new rate applies at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   presc <= RESET_DB_PERIOD;
      else if (wr && address == 3'd6) presc <= writedata[15:0];
      else if (tick)                  presc <= db_period;
      else                            presc <= presc - 16'd1;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      button_pio_dbnc_lane #(.DB_TICKS(DB_TICKS), .RST_LEVEL(RESET_LEVEL[i])) u_lane (
         .clk    (clk),
         .reset_n(reset_n),
         .sync   (sync[i]),
         .tick   (tick),
         .bypass (bypass),
         .db     (db[i])
      );
   end

   assign rise = db & ~db_d1 & rise_en;
   assign fall = ~db & db_d1 & fall_en;
   assign w1c  = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_d1        <= RESET_LEVEL;
         edge_capture <= '0;
         irq_mask     <= '0;
         rise_en      <= '0;
         fall_en      <= '0;
         db_period    <= RESET_DB_PERIOD;
      end else begin
         db_d1        <= db;
         // A new edge in the same cycle as its clear keeps the bit set.
         edge_capture <= (edge_capture & ~w1c) | rise | fall;
         if (wr) begin
            case (address)
               3'd2:    irq_mask  <= writedata[WIDTH-1:0];
               3'd4:    rise_en   <= writedata[WIDTH-1:0];
               3'd5:    fall_en   <= writedata[WIDTH-1:0];
               3'd6:    db_period <= writedata[15:0];
               default: ;
            endcase
         end
      end
   end

   assign irq = |(edge_capture & irq_mask);

   always_comb begin
      rd_next = '0;
      case (address)
         3'd0:    rd_next[WIDTH-1:0] = db;
         3'd1:    rd_next[WIDTH-1:0] = sync;
         3'd2:    rd_next[WIDTH-1:0] = irq_mask;
         3'd3:    rd_next[WIDTH-1:0] = edge_capture;
         3'd4:    rd_next[WIDTH-1:0] = rise_en;
         3'd5:    rd_next[WIDTH-1:0] = fall_en;
         3'd6:    rd_next[15:0]      = db_period;
         default: rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_next;
   end
endmodule

// File: tb/tb_button_pio_dbnc.sv
// Scoreboard bench: reads push expected data from a level/edge model; a monitor checks readdata and irq.

module tb_button_pio_dbnc;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   button_pio_dbnc dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] d; logic irq; } exp_t;
   exp_t  exp_q[$];
   string name_q[$];
   int    total = 0;
   int    bad = 0;
   logic  rd_req = 1'b0;
   logic  rd_vld = 1'b0;

   // model of the architectural state
   logic [3:0]  m_level, m_ec, m_mask, m_rise, m_fall;
   logic [15:0] m_period;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_level = 4'hF; m_ec = 0; m_mask = 0; m_rise = 0; m_fall = 0; m_period = 16'd50000;
   endtask

   // Accepted level change: each toggled channel contributes its enabled edge.
   task automatic settle(input logic [3:0] nl);
      for (int i = 0; i < 4; i++)
         if (nl[i] != m_level[i]) m_ec[i] = m_ec[i] | (nl[i] ? m_rise[i] : m_fall[i]);
      m_level = nl;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      case (a)
         3'd2: m_mask = d[3:0];
         3'd3: m_ec = m_ec & ~d[3:0];
         3'd4: m_rise = d[3:0];
         3'd5: m_fall = d[3:0];
         3'd6: m_period = d[15:0];
         default: ;
      endcase
   endtask

   task automatic rd(input logic [2:0] a, input string nm);
      logic [31:0] e;
      case (a)
         3'd0, 3'd1: e = {28'd0, m_level};
         3'd2: e = {28'd0, m_mask};
         3'd3: e = {28'd0, m_ec};
         3'd4: e = {28'd0, m_rise};
         3'd5: e = {28'd0, m_fall};
         3'd6: e = {16'd0, m_period};
         default: e = 32'd0;
      endcase
      @(negedge clk);
      address = a; rd_req = 1'b1;
      exp_q.push_back({e, |(m_ec & m_mask)});
      name_q.push_back(nm);
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   always @(posedge clk) rd_vld <= rd_req;

   always @(negedge clk) begin
      if (rd_vld) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, "_data"}, readdata, e.d);
            chk({nm, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
         end
      end
   end

   initial begin
      int n;
      logic [3:0] v;
      reset_n = 1'b0; address = 0; chipselect = 0; write_n = 1; writedata = 0; in_port = 4'hF;
      model_reset();
      #3;
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      cyc(3);
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) rd(3'(a), $sformatf("rst_reg%0d", a));

      // glitch shorter than the debounce window
      wr(6, 3); wr(5, 4'hF); wr(2, 4'hF);
      @(negedge clk); in_port[0] = 1'b0;
      cyc(10); in_port[0] = 1'b1;
      cyc(30);
      rd(0, "glitch_db"); rd(3, "glitch_ec");

      // stable press
      @(negedge clk); in_port[0] = 1'b0;
      for (n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (irq) break;
      end
      chk("press_latency_ok", {31'd0, n <= 24}, 32'd1);
      settle(4'hE);
      rd(0, "press_db"); rd(3, "press_ec");

      // W1C of individual bits
      @(negedge clk); in_port[2] = 1'b0;
      cyc(40); settle(4'hA);
      rd(3, "w1c_pre");
      wr(3, 4); rd(3, "w1c_bit2");
      wr(3, 1); rd(3, "w1c_bit0");
      @(negedge clk); in_port = 4'hF;
      cyc(40); settle(4'hF);
      rd(0, "release_db");

      // bypass: only the enabled rise is captured
      wr(6, 0); wr(4, 2); wr(5, 0);
      @(negedge clk); in_port[1] = 1'b0;
      cyc(8); settle(4'hD);
      rd(3, "bypass_fall_ignored");
      @(negedge clk); in_port[1] = 1'b1;
      for (n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (irq) break;
      end
      chk("bypass_latency_ok", {31'd0, n <= 4}, 32'd1);
      settle(4'hF);
      rd(3, "bypass_rise");

      // set and clear of bit 2 in the same cycle
      wr(3, 4'hF); wr(5, 4);
      @(negedge clk); in_port[2] = 1'b0;
      cyc(6); settle(4'hB);
      @(negedge clk); in_port[2] = 1'b1;
      cyc(6); settle(4'hF);
      rd(3, "collide_pre");
      @(negedge clk); in_port[2] = 1'b0;
      cyc(3);
      address = 3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'd4;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      settle(4'hB);
      rd(3, "collide_set_wins");
      @(negedge clk); in_port[2] = 1'b1;
      cyc(6); settle(4'hF);

      // random long holds and short glitches with debounce active
      wr(6, 3); wr(3, 4'hF);
      wr(4, $urandom_range(0, 15)); wr(5, $urandom_range(0, 15)); wr(2, $urandom_range(1, 15));
      for (int it = 0; it < 12; it++) begin
         int c;
         c = $urandom_range(0, 3);
         @(negedge clk);
         in_port[c] = ~in_port[c];
         if ($urandom_range(0, 1) == 1) begin
            cyc(40);
            settle(in_port);
         end else begin
            cyc($urandom_range(1, 8));
            in_port[c] = ~in_port[c];
            cyc(8);
         end
         rd(0, "rnd_db"); rd(1, "rnd_raw"); rd(3, "rnd_ec");
         if ($urandom_range(0, 3) == 0) begin
            wr(3, $urandom_range(0, 15)); rd(3, "rnd_w1c");
         end
      end

      // random bursts in bypass: every change is accepted
      wr(6, 0); wr(3, 4'hF); wr(4, $urandom_range(0, 15)); wr(5, $urandom_range(0, 15));
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 3; k++) begin
            v = 4'($urandom_range(1, 15));
            @(negedge clk);
            in_port = in_port ^ v;
            settle(in_port);
            cyc($urandom_range(0, 3));
         end
         cyc(6);
         rd(0, "byp_db"); rd(3, "byp_ec");
      end
      @(negedge clk); in_port = 4'hF;
      cyc(6); settle(4'hF);
      rd(3, "byp_final_ec");

      // reset during a partial debounce of channel 3
      wr(6, 3); wr(5, 4'hF);
      cyc(4);
      in_port[3] = 1'b0;
      cyc(8);
      reset_n = 1'b0;
      in_port = 4'hF;
      model_reset();
      cyc(3);
      reset_n = 1'b1;
      cyc(40);
      chk("midrst_irq", {31'd0, irq}, 32'd0);
      rd(0, "midrst_db"); rd(3, "midrst_ec"); rd(6, "midrst_period"); rd(2, "midrst_mask");

      for (n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
